// File: rtl/aes_pkg.sv
// Shared state type and constants for the AES round scheduler.
// Round counts and mode encodings are common to aes_round_sched and aes_round_cnt.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROUND,
        HOLD
    } state_t;

    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic logic nr_supported(input int unsigned nr);
        return (nr == NR_128) || (nr == NR_192) || (nr == NR_256);
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round counter with terminal-count flags and round-key address mapping.
// Reverse (decrypt) addressing exists only when AES_DEC_EN is defined.
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_128,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    input  logic          mode_i,
    output logic          tc_o,
    output logic          tc_next_o,
    output logic [AW-1:0] addr_next_o
);

    localparam logic [AW-1:0] NR_A = AW'(NR);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o      = (cnt_q == NR_A);
    assign tc_next_o = (cnt_d == NR_A);

    // Address follows the next count so the registered key_addr lines up with rnd_en.
`ifdef AES_DEC_EN
    assign addr_next_o = (mode_i == MODE_DEC) ? (NR_A - cnt_d) : cnt_d;
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign addr_next_o = cnt_d;
`endif

endmodule

// File: rtl/aes_round_sched.sv
// AES round scheduler: sequences initial AddRoundKey, NR-1 rounds and final round.
// Define AES_DEC_EN to enable decryption (reverse round-key addressing).
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_128,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_loaded,
    input  logic          start_valid,
    input  logic          start_mode,
    output logic          start_ready,
    output logic [AW-1:0] key_addr,
    output logic          rnd_en,
    output logic          rnd_first,
    output logic          rnd_last,
    output logic          rnd_mode,
    output logic          done_valid,
    input  logic          done_ready,
    output logic          abort,
    output logic          crypto_ready
);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          req_mode;
    logic          cnt_load, cnt_inc;
    logic          tc, tc_next;
    logic [AW-1:0] addr_next;

    logic [AW-1:0] key_addr_q, key_addr_d;
    logic          rnd_en_q, rnd_en_d;
    logic          rnd_first_q, rnd_first_d;
    logic          rnd_last_q, rnd_last_d;
    logic          done_valid_q, done_valid_d;
    logic          abort_q, abort_d;

`ifdef AES_DEC_EN
    assign req_mode = start_mode;
`else
    logic unused_start_mode;
    assign unused_start_mode = start_mode;
    assign req_mode = MODE_ENC;
`endif

    aes_round_cnt #(
        .NR(NR),
        .AW(AW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .inc_i      (cnt_inc),
        .mode_i     (mode_d),
        .tc_o       (tc),
        .tc_next_o  (tc_next),
        .addr_next_o(addr_next)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_valid && key_loaded) begin
                    state_d  = INIT;
                    mode_d   = req_mode;
                    cnt_load = 1'b1;
                end
            end
            INIT: begin
                if (!key_loaded) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    state_d = ROUND;
                    cnt_inc = 1'b1;
                end
            end
            ROUND: begin
                if (!key_loaded) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (tc) begin
                    state_d = HOLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                // A transfer completing as the key drops still counts as delivered.
                if (done_ready) begin
                    state_d = IDLE;
                end else if (!key_loaded) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they align with it.
    always_comb begin
        rnd_en_d     = (state_d == INIT) || (state_d == ROUND);
        rnd_first_d  = (state_d == INIT);
        rnd_last_d   = (state_d == ROUND) && tc_next;
        done_valid_d = (state_d == HOLD);
        key_addr_d   = rnd_en_d ? addr_next : key_addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mode_q       <= MODE_ENC;
            key_addr_q   <= '0;
            rnd_en_q     <= 1'b0;
            rnd_first_q  <= 1'b0;
            rnd_last_q   <= 1'b0;
            done_valid_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            key_addr_q   <= key_addr_d;
            rnd_en_q     <= rnd_en_d;
            rnd_first_q  <= rnd_first_d;
            rnd_last_q   <= rnd_last_d;
            done_valid_q <= done_valid_d;
            abort_q      <= abort_d;
        end
    end

    assign start_ready  = (state_q == IDLE) && key_loaded;
    assign crypto_ready = start_ready;
    assign key_addr     = key_addr_q;
    assign rnd_en       = rnd_en_q;
    assign rnd_first    = rnd_first_q;
    assign rnd_last     = rnd_last_q;
    assign rnd_mode     = mode_q;
    assign done_valid   = done_valid_q;
    assign abort        = abort_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched against a cycles-since-accept reference model.
// Honours AES_DEC_EN when predicting addresses and rnd_mode.
module tb_aes_round_sched;

    localparam int NR = 10;
    localparam int AW = 4;

`ifdef AES_DEC_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key_loaded = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_mode = 1'b0;
    logic          done_ready = 1'b0;
    logic          start_ready, crypto_ready;
    logic [AW-1:0] key_addr;
    logic          rnd_en, rnd_first, rnd_last, rnd_mode, done_valid, abort;

    aes_round_sched #(
        .NR(NR),
        .AW(AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_loaded  (key_loaded),
        .start_valid (start_valid),
        .start_mode  (start_mode),
        .start_ready (start_ready),
        .key_addr    (key_addr),
        .rnd_en      (rnd_en),
        .rnd_first   (rnd_first),
        .rnd_last    (rnd_last),
        .rnd_mode    (rnd_mode),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .abort       (abort),
        .crypto_ready(crypto_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_q[$];

    // Model: k counts cycles since accept (1 = AddRoundKey, NR+1 = final round, >= NR+2 = result held).
    bit m_busy;
    int m_k;
    bit m_mode;
    int m_addr;
    bit m_abort;
    bit prev_dv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_k     = 0;
        m_mode  = 1'b0;
        m_addr  = 0;
        m_abort = 1'b0;
        prev_dv = 1'b0;
    endtask

    task automatic model_step(input logic kl, input logic sv, input logic sm, input logic dr);
        m_abort = 1'b0;
        if (!m_busy) begin
            if (sv && kl) begin
                m_busy  = 1'b1;
                m_k     = 1;
                m_mode  = DEC ? sm : 1'b0;
                acc_cyc = cyc;
                acc_q.push_back(cyc);
            end
        end else if (m_k >= NR + 2) begin
            if (dr) begin
                m_busy = 1'b0;
            end else if (!kl) begin
                m_busy  = 1'b0;
                m_abort = 1'b1;
            end
        end else if (!kl) begin
            m_busy  = 1'b0;
            m_abort = 1'b1;
        end else begin
            m_k++;
        end
        if (m_busy && m_k <= NR + 1) m_addr = m_mode ? NR - (m_k - 1) : m_k - 1;
    endtask

    task automatic cycle(input logic r, input logic kl, input logic sv, input logic sm, input logic dr);
        @(negedge clk);
        rst = r;
        key_loaded = kl;
        start_valid = sv;
        start_mode = sm;
        done_ready = dr;
        #1;
        cyc++;
        chk("key_addr", key_addr, m_addr);
        chk("rnd_en", rnd_en, m_busy && m_k <= NR + 1);
        chk("rnd_first", rnd_first, m_busy && m_k == 1);
        chk("rnd_last", rnd_last, m_busy && m_k == NR + 1);
        chk("done_valid", done_valid, m_busy && m_k >= NR + 2);
        chk("rnd_mode", rnd_mode, m_mode);
        chk("abort", abort, m_abort);
        chk("start_ready", start_ready, !m_busy && kl);
        chk("crypto_ready", crypto_ready, !m_busy && kl);
        if (done_valid && !prev_dv) chk("latency", cyc - acc_cyc, NR + 2);
        prev_dv = done_valid;
        if (!r) model_reset();
        else model_step(kl, sv, sm, dr);
    endtask

    initial begin
        model_reset();
        // Reset held with a pending request and no key.
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Encrypt block.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (NR + 4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Decrypt block.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (NR + 4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Stall in HOLD with a new request pending.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (NR + 1) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (NR + 4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Key reload while in ROUND with rc = 4.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Back-to-back blocks.
        acc_q.delete();
        repeat (3 * (NR + 3)) cycle(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        chk("b2b_count", acc_q.size(), 3);
        for (int i = 1; i < acc_q.size(); i++) chk("ii", acc_q[i] - acc_q[i-1], NR + 3);
        repeat (NR + 4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomised traffic with occasional key reloads and stalls.
        repeat (400) cycle(1'b1, ($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        repeat (NR + 4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-block.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_rnd_en", rnd_en, 1'b0);
        chk("arst_key_addr", key_addr, 0);
        chk("arst_rnd_mode", rnd_mode, 1'b0);
        chk("arst_abort", abort, 1'b0);
        chk("arst_done_valid", done_valid, 1'b0);
        model_reset();
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (NR + 4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
